hdmi_mode_sequencer: RTL and testbench

Controller that sequences the HDMI encoder and scandoubler across power-up, PLL lock and Atari ST video-mode changes (PAL/NTSC/mono). It sits in the pixel-clock domain between the video analyzer and the hdmi/scandoubler instances. It holds the encoder in reset until the detected mode has been stable for a set number of frames, then releases it aligned to the analyzer's resync pulse. On a mode change it mutes audio before re-entering reset, so mode switches never produce torn frames or audio clicks.

---
 rtl/hdmi_mode_sequencer.sv | 168 ++++++++++++++++
 tb/tb_hdmi_mode_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_mode_sequencer.sv
// hdmi_mode_sequencer: holds the HDMI encoder in reset until the ST video mode is stable, releases it on the analyzer resync, mutes audio ahead of mode changes.
// All outputs registered (no backpressure); define HDMI_SEQ_BLANK_EN to force video_blank outside RUN.
module hdmi_mode_sequencer #(
   parameter int SETTLE_FRAMES = 4,
   parameter int MUTE_CYCLES   = 64,
   parameter int ALIGN_TIMEOUT = 1048576
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       vs_n,
   input  logic [1:0] mode_in,
   input  logic       vreset_in,
   output logic [1:0] mode_out,
   output logic       hdmi_reset,
   output logic       sd_bypass,
   output logic       audio_mute,
   output logic       aligned,
   output logic       video_blank
);

   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_FRAMES);
   localparam logic [7:0]  MUTE_LAST   = 8'(MUTE_CYCLES - 1);
   localparam logic [20:0] TMO_LAST    = 21'(ALIGN_TIMEOUT - 1);
`ifdef HDMI_SEQ_BLANK_EN
   localparam logic BLANK_ON = 1'b1;
`else
   localparam logic BLANK_ON = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_SETTLE,
      S_ALIGN,
      S_RUN,
      S_MUTE
   } state_t;

   state_t      r_state;
   logic        r_lock_s1;
   logic        r_lock_s2;
   logic        r_vs_d1;
   logic        r_vs_d2;
   logic        r_frame_start;
   logic [1:0]  r_cand;
   logic [3:0]  r_cnt;
   logic [7:0]  r_mcnt;
   logic [20:0] r_tmo;
   logic [1:0]  r_mode_out;
   logic        r_hdmi_reset;
   logic        r_sd_bypass;
   logic        r_audio_mute;
   logic        r_aligned;
   logic        r_video_blank;

   logic [3:0]  w_cnt_inc;
   logic [7:0]  w_mcnt_inc;
   logic [20:0] w_tmo_inc;
   logic        w_mode_hit;

   assign w_cnt_inc  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
   assign w_mcnt_inc = (r_mcnt == 8'hFF) ? r_mcnt : r_mcnt + 8'd1;
   assign w_tmo_inc  = (r_tmo == '1) ? r_tmo : r_tmo + 21'd1;
   assign w_mode_hit = (mode_in == r_cand) && (mode_in != 2'd3);

   // vs_n is edge-detected on registered copies so frame_start is a clean one-cycle pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock_s1     <= 1'b0;
         r_lock_s2     <= 1'b0;
         r_vs_d1       <= 1'b1;
         r_vs_d2       <= 1'b1;
         r_frame_start <= 1'b0;
      end else begin
         r_lock_s1     <= pll_lock;
         r_lock_s2     <= r_lock_s1;
         r_vs_d1       <= vs_n;
         r_vs_d2       <= r_vs_d1;
         r_frame_start <= r_vs_d2 & ~r_vs_d1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_WAIT_LOCK;
         r_cand        <= 2'd0;
         r_cnt         <= 4'd0;
         r_mcnt        <= 8'd0;
         r_tmo         <= 21'd0;
         r_mode_out    <= 2'd0;
         r_hdmi_reset  <= 1'b1;
         r_sd_bypass   <= 1'b0;
         r_audio_mute  <= 1'b1;
         r_aligned     <= 1'b0;
         r_video_blank <= 1'b1;
      end else if (!r_lock_s2) begin
         // Lock loss overrides everything; mode_out and aligned keep their last values.
         r_state       <= S_WAIT_LOCK;
         r_hdmi_reset  <= 1'b1;
         r_audio_mute  <= 1'b1;
         r_video_blank <= BLANK_ON;
      end else begin
         case (r_state)
            S_WAIT_LOCK: begin
               r_cand  <= mode_in;
               r_cnt   <= 4'd0;
               r_state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (r_frame_start) begin
                  if (w_mode_hit) begin
                     r_cnt <= w_cnt_inc;
                     if (w_cnt_inc == SETTLE_LAST) begin
                        r_mode_out  <= r_cand;
                        r_sd_bypass <= (r_cand == 2'd2);
                        r_tmo       <= 21'd0;
                        r_state     <= S_ALIGN;
                     end
                  end else begin
                     r_cand <= mode_in;
                     r_cnt  <= 4'd0;
                  end
               end
            end
            S_ALIGN: begin
               if (vreset_in || (r_tmo == TMO_LAST)) begin
                  r_aligned     <= vreset_in;
                  r_hdmi_reset  <= 1'b0;
                  r_audio_mute  <= 1'b0;
                  r_video_blank <= 1'b0;
                  r_state       <= S_RUN;
               end else begin
                  r_tmo <= w_tmo_inc;
               end
            end
            S_RUN: begin
               if (r_frame_start && (mode_in != r_mode_out)) begin
                  r_mcnt        <= 8'd0;
                  r_audio_mute  <= 1'b1;
                  r_video_blank <= BLANK_ON;
                  r_state       <= S_MUTE;
               end
            end
            S_MUTE: begin
               if (r_mcnt == MUTE_LAST) begin
                  r_cand       <= mode_in;
                  r_cnt        <= 4'd0;
                  r_hdmi_reset <= 1'b1;
                  r_state      <= S_SETTLE;
               end else begin
                  r_mcnt <= w_mcnt_inc;
               end
            end
            default: begin
               r_state <= S_WAIT_LOCK;
            end
         endcase
      end
   end

   assign mode_out    = r_mode_out;
   assign hdmi_reset  = r_hdmi_reset;
   assign sd_bypass   = r_sd_bypass;
   assign audio_mute  = r_audio_mute;
   assign aligned     = r_aligned;
   assign video_blank = r_video_blank;

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// Bench for hdmi_mode_sequencer: randomized frame/mode stimulus, expected output changes queued per cycle
// and popped by an independent monitor whenever any DUT output changes.
module tb_hdmi_mode_sequencer;

   localparam int SETTLE_FRAMES = 4;
   localparam int MUTE_CYCLES   = 64;
   localparam int ALIGN_TIMEOUT = 1000;

   logic       clk = 1'b0;
   logic       reset;
   logic       pll_lock;
   logic       vs_n;
   logic [1:0] mode_in;
   logic       vreset_in;
   logic [1:0] mode_out;
   logic       hdmi_reset;
   logic       sd_bypass;
   logic       audio_mute;
   logic       aligned;
   logic       video_blank;

   hdmi_mode_sequencer #(
      .SETTLE_FRAMES(SETTLE_FRAMES),
      .MUTE_CYCLES  (MUTE_CYCLES),
      .ALIGN_TIMEOUT(ALIGN_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .vs_n       (vs_n),
      .mode_in    (mode_in),
      .vreset_in  (vreset_in),
      .mode_out   (mode_out),
      .hdmi_reset (hdmi_reset),
      .sd_bypass  (sd_bypass),
      .audio_mute (audio_mute),
      .aligned    (aligned),
      .video_blank(video_blank)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [1:0] mode;
      logic       hr;
      logic       sd;
      logic       mute;
      logic       al;
      logic       blank;
   } ev_t;

   ev_t  exp_q[$];
   ev_t  last_exp;
   bit   have_last = 1'b0;

   // Expected architectural view of the outputs, updated by the stimulus as it applies the rules.
   logic [1:0] e_mode;
   logic       e_hr, e_sd, e_mute, e_al, e_rst;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   bit final_chk = 1'b0;

   function automatic logic exp_blank();
`ifdef HDMI_SEQ_BLANK_EN
      return e_rst | e_hr | e_mute;
`else
      return e_rst;
`endif
   endfunction

   function automatic bit same_vals(input ev_t a, input ev_t b);
      return (a.mode == b.mode) && (a.hr == b.hr) && (a.sd == b.sd) &&
             (a.mute == b.mute) && (a.al == b.al) && (a.blank == b.blank);
   endfunction

   task automatic expect_at(input int c);
      ev_t e;
      e.c = c; e.mode = e_mode; e.hr = e_hr; e.sd = e_sd;
      e.mute = e_mute; e.al = e_al; e.blank = exp_blank();
      if (!have_last || !same_vals(e, last_exp)) begin
         exp_q.push_back(e);
         last_exp  = e;
         have_last = 1'b1;
      end
   endtask

   // Monitor: every change on the outputs must match the next queued expectation, at its cycle.
   ev_t act, prev_act, ex;
   bit  started = 1'b0;
   bit  final_done = 1'b0;
   always @(negedge clk) begin
      if (mon_en) begin
         act.c = cyc; act.mode = mode_out; act.hr = hdmi_reset; act.sd = sd_bypass;
         act.mute = audio_mute; act.al = aligned; act.blank = video_blank;
         if (!started || !same_vals(act, prev_act)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change cyc=%0d got mode=%0d hr=%0b sd=%0b mute=%0b al=%0b blank=%0b, no change expected",
                        act.c, act.mode, act.hr, act.sd, act.mute, act.al, act.blank);
            end else begin
               ex = exp_q.pop_front();
               if (ex.c != act.c || !same_vals(act, ex)) begin
                  errors++;
                  $display("FAIL output_event got cyc=%0d mode=%0d hr=%0b sd=%0b mute=%0b al=%0b blank=%0b, required cyc=%0d mode=%0d hr=%0b sd=%0b mute=%0b al=%0b blank=%0b",
                           act.c, act.mode, act.hr, act.sd, act.mute, act.al, act.blank,
                           ex.c, ex.mode, ex.hr, ex.sd, ex.mute, ex.al, ex.blank);
               end
            end
            prev_act = act;
            started  = 1'b1;
         end
         if (final_chk && !final_done) begin
            final_done = 1'b1;
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL pending_events got %0d outstanding (next at cyc=%0d), required 0",
                        exp_q.size(), exp_q[0].c);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One vsync frame; consume is the edge on which the sequencer acts on this frame.
   task automatic do_frame(input int gap, input logic [1:0] m, input bit vr, output int consume);
      mode_in = m;
      if (vr) begin
         tick(1);
         vreset_in = 1'b1;
         tick(1);
         vreset_in = 1'b0;
         tick(gap - 2);
      end else begin
         tick(gap);
      end
      vs_n    = 1'b0;
      consume = cyc + 3;
      tick(3);
      vs_n    = 1'b1;
   endtask

   // Feeds frames until the reference rule (SETTLE_FRAMES identical valid modes) is met.
   task automatic settle(input int start_edge, input logic [1:0] start_cand, input int nrand,
                         input logic [1:0] target, output int rel);
      logic [1:0] cand, m;
      int cnt, c, nf;
      cand = start_cand; cnt = 0; rel = -1; nf = 0;
      while (rel < 0) begin
         m = (nf < nrand) ? 2'($urandom_range(0, 3)) : target;
         do_frame($urandom_range(6, 24), m, ($urandom_range(0, 3) == 0), c);
         nf++;
         if (c > start_edge) begin
            if (m == cand && m != 2'd3) begin
               cnt++;
               if (cnt == SETTLE_FRAMES) rel = c;
            end else begin
               cand = m;
               cnt  = 0;
            end
         end
      end
      e_mode = cand;
      e_sd   = (cand == 2'd2);
      expect_at(rel);
   endtask

   // kind 0: vreset after random delay, 1: timeout only, 2: vreset on the timeout cycle.
   task automatic align(input int rel, input int kind);
      int d;
      e_hr = 1'b0; e_mute = 1'b0;
      case (kind)
         0: begin
            d = $urandom_range(0, 40);
            tick(d);
            vreset_in = 1'b1;
            e_al = 1'b1;
            expect_at(cyc + 1);
            tick(1);
            vreset_in = 1'b0;
         end
         1: begin
            e_al = 1'b0;
            expect_at(rel + ALIGN_TIMEOUT);
            tick(ALIGN_TIMEOUT);
         end
         default: begin
            tick(ALIGN_TIMEOUT - 1);
            vreset_in = 1'b1;
            e_al = 1'b1;
            expect_at(rel + ALIGN_TIMEOUT);
            tick(1);
            vreset_in = 1'b0;
         end
      endcase
   endtask

   task automatic mode_change(input logic [1:0] m, input int nrand, input logic [1:0] target, input int kind);
      int c, c2, rel;
      do_frame(8, m, 1'b0, c);
      e_mute = 1'b1;
      expect_at(c);
      e_hr = 1'b1;
      expect_at(c + MUTE_CYCLES);
      do_frame(12, m, 1'b0, c2);
      tick(c + MUTE_CYCLES - cyc);
      settle(c + MUTE_CYCLES, m, nrand, target, rel);
      align(rel, kind);
   endtask

   int         lk, rel, cdum;
   logic [1:0] m;

   initial begin
      reset = 1'b1; pll_lock = 1'b0; vs_n = 1'b1; vreset_in = 1'b0; mode_in = 2'd0;
      e_mode = 2'd0; e_hr = 1'b1; e_sd = 1'b0; e_mute = 1'b1; e_al = 1'b0; e_rst = 1'b1;
      tick(2);
      mon_en = 1'b1;
      expect_at(cyc);
      reset = 1'b0;
      e_rst = 1'b0;
      expect_at(cyc + 1);
      tick(100);

      // Power-up: a frame acted on exactly on the lock-exit edge must not count.
      pll_lock = 1'b1;
      vs_n = 1'b0;
      lk = cyc;
      tick(3);
      vs_n = 1'b1;
      settle(lk + 3, 2'd0, 0, 2'd0, rel);
      align(rel, 0);

      // Mode change into mono, released by timeout.
      mode_change(2'd2, 0, 2'd2, 1);
      // Unstable modes before settling on NTSC; vreset coincides with timeout.
      mode_change(2'd0, 10, 2'd1, 2);

      // RUN: mid-frame glitch and stray vreset are ignored.
      mode_in = e_mode + 2'd1;
      tick(5);
      vreset_in = 1'b1;
      mode_in = e_mode;
      tick(1);
      vreset_in = 1'b0;
      do_frame(10, e_mode, 1'b0, cdum);

      // Lock loss in RUN, then relock.
      pll_lock = 1'b0;
      e_hr = 1'b1; e_mute = 1'b1;
      expect_at(cyc + 3);
      tick(20);
      pll_lock = 1'b1;
      lk = cyc;
      tick(3);
      settle(lk + 3, e_mode, 3, 2'($urandom_range(0, 2)), rel);
      align(rel, 0);

      for (int i = 0; i < 2; i++) begin
         do m = 2'($urandom_range(0, 3)); while (m == e_mode);
         mode_change(m, $urandom_range(0, 6), 2'($urandom_range(0, 2)), $urandom_range(0, 2));
      end

      // Reset while running returns every output, including mode_out, to its reset value.
      tick(7);
      reset = 1'b1;
      e_mode = 2'd0; e_hr = 1'b1; e_sd = 1'b0; e_mute = 1'b1; e_al = 1'b0; e_rst = 1'b1;
      expect_at(cyc + 1);
      tick(2);
      reset = 1'b0;
      e_rst = 1'b0;
      expect_at(cyc + 1);
      tick(20);

      final_chk = 1'b1;
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
